// File: rtl/branch_unit_if.sv
// Bundle of decode inputs, ALU flags and next-PC outputs between the datapath
// and the branch-resolution block.
interface branch_unit_if #(
  parameter int PC_W = 8,
  parameter int RA_W = 32
);
  logic [2:0]      opcode;
  logic [3:0]      fcode;
  logic [PC_W-1:0] branch_addr;
  logic            carryFlag;
  logic            zeroFlag;
  logic            overflowFlag;
  logic            signFlag;
  logic [PC_W-1:0] PC;
  logic [PC_W-1:0] branch_PC;
  logic            PC_select;
  logic [RA_W-1:0] ra;

  modport master (
    output opcode, fcode, branch_addr, carryFlag, zeroFlag, overflowFlag,
           signFlag, PC,
    input  branch_PC, PC_select, ra
  );

  modport slave (
    input  opcode, fcode, branch_addr, carryFlag, zeroFlag, overflowFlag,
           signFlag, PC,
    output branch_PC, PC_select, ra
  );
endinterface

// File: rtl/branch_unit.sv
// KGP-RISC branch resolution: combinational taken/target decode against the ALU
// flags, plus the clocked return-address register used by call/ret.
module branch_unit #(
  parameter int PC_W = 8,
  parameter int RA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  branch_unit_if.slave bus
);

  localparam logic [2:0] OP_BRANCH = 3'b011;

  typedef enum logic [3:0] {
    F_B    = 4'b0000,
    F_BZ   = 4'b0001,
    F_BNZ  = 4'b0010,
    F_BCY  = 4'b0011,
    F_BNCY = 4'b0100,
    F_BS   = 4'b0101,
    F_BNS  = 4'b0110,
    F_BV   = 4'b0111,
    F_BNV  = 4'b1000,
    F_CALL = 4'b1001,
    F_RET  = 4'b1010
  } fcode_e;

  logic [RA_W-1:0] ra_q;
  logic [RA_W-1:0] ra_d;
  logic [PC_W-1:0] pc_inc_s;
  logic            is_branch_s;
  logic            taken_s;
  logic [PC_W-1:0] target_s;

  // Taken decision and next-PC target; only the flag named by fcode is looked at.
  always_comb begin
    pc_inc_s    = bus.PC + {{(PC_W-1){1'b0}}, 1'b1};
    is_branch_s = (bus.opcode == OP_BRANCH);
    taken_s     = 1'b0;
    target_s    = bus.branch_addr;
    if (is_branch_s) begin
      case (bus.fcode)
        F_B:     taken_s = 1'b1;
        F_BZ:    taken_s = bus.zeroFlag;
        F_BNZ:   taken_s = ~bus.zeroFlag;
        F_BCY:   taken_s = bus.carryFlag;
        F_BNCY:  taken_s = ~bus.carryFlag;
        F_BS:    taken_s = bus.signFlag;
        F_BNS:   taken_s = ~bus.signFlag;
        F_BV:    taken_s = bus.overflowFlag;
        F_BNV:   taken_s = ~bus.overflowFlag;
        F_CALL:  taken_s = 1'b1;
        F_RET: begin
          taken_s  = 1'b1;
          // ret uses the pre-update register value, so a same-cycle call cannot bypass.
          target_s = ra_q[PC_W-1:0];
        end
        default: taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
  end

  // Return address captures PC+1 on call, otherwise holds.
  always_comb begin
    ra_d = ra_q;
    if (is_branch_s && (bus.fcode == F_CALL)) begin
      ra_d = {{(RA_W-PC_W){1'b0}}, pc_inc_s};
    end else begin
      ra_d = ra_q;
    end
  end

  // Return-address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q <= {RA_W{1'b0}};
    end else begin
      ra_q <= ra_d;
    end
  end

  assign bus.PC_select = taken_s;
  assign bus.branch_PC = taken_s ? target_s : pc_inc_s;
  assign bus.ra        = ra_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit: decode sweep, call/ret, reserved,
// wrap-around and reset-vs-call ordering.
module tb_branch_unit;

  localparam int PC_W = 8;
  localparam int RA_W = 32;

  logic clk;
  logic rst;
  int   err_cnt;
  int   chk_cnt;

  branch_unit_if #(.PC_W(PC_W), .RA_W(RA_W)) bus ();

  branch_unit #(.PC_W(PC_W), .RA_W(RA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (obs !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic c, input logic z, input logic v, input logic s);
    bus.carryFlag    = c;
    bus.zeroFlag     = z;
    bus.overflowFlag = v;
    bus.signFlag     = s;
  endtask

  initial begin
    logic [3:0] f_pos;
    logic [3:0] f_neg;
    logic       fl;
    err_cnt = 0;
    chk_cnt = 0;

    // Reset, then ret decode while in reset: ra=0 and ret targets 0
    rst = 1'b1;
    bus.opcode      = 3'b011;
    bus.fcode       = 4'b1010;
    bus.branch_addr = 8'd35;
    bus.PC          = 8'd10;
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check_val("rst_ra", bus.ra, 32'd0);
    check_val("rst_ret_sel", {31'd0, bus.PC_select}, 32'd1);
    check_val("rst_ret_pc", {24'd0, bus.branch_PC}, 32'd0);
    edge_step();
    rst = 1'b0;
    #1;

    // Unconditional branch
    bus.fcode = 4'b0000;
    #1;
    check_val("b_sel", {31'd0, bus.PC_select}, 32'd1);
    check_val("b_pc", {24'd0, bus.branch_PC}, 32'd35);

    // Flag sweep; other flags driven to the opposite value to show they are ignored
    for (int i = 0; i < 4; i++) begin
      f_pos = 4'(1 + 2 * i);
      f_neg = 4'(2 + 2 * i);
      for (int v = 1; v >= 0; v--) begin
        fl = v[0];
        case (i)
          0: set_flags(~fl, fl, ~fl, ~fl);
          1: set_flags(fl, ~fl, ~fl, ~fl);
          2: set_flags(~fl, ~fl, ~fl, fl);
          default: set_flags(~fl, ~fl, fl, ~fl);
        endcase
        bus.fcode = f_pos;
        #1;
        check_val($sformatf("pos%0d_f%0d_sel", i, v), {31'd0, bus.PC_select}, {31'd0, fl});
        check_val($sformatf("pos%0d_f%0d_pc", i, v), {24'd0, bus.branch_PC}, fl ? 32'd35 : 32'd11);
        bus.fcode = f_neg;
        #1;
        check_val($sformatf("neg%0d_f%0d_sel", i, v), {31'd0, bus.PC_select}, {31'd0, ~fl});
        check_val($sformatf("neg%0d_f%0d_pc", i, v), {24'd0, bus.branch_PC}, fl ? 32'd11 : 32'd35);
      end
    end

    // Call at PC=20, then ret returns to 21
    set_flags(1'b0, 1'b0, 1'b0, 1'b0);
    bus.PC    = 8'd20;
    bus.fcode = 4'b1001;
    #1;
    check_val("call_sel", {31'd0, bus.PC_select}, 32'd1);
    check_val("call_pc", {24'd0, bus.branch_PC}, 32'd35);
    check_val("call_ra_pre", bus.ra, 32'd0);
    edge_step();
    check_val("call_ra", bus.ra, 32'd21);
    edge_step();
    check_val("call_hold_ra", bus.ra, 32'd21);
    bus.fcode = 4'b1010;
    #1;
    check_val("ret_sel", {31'd0, bus.PC_select}, 32'd1);
    check_val("ret_pc", {24'd0, bus.branch_PC}, 32'd21);
    edge_step();
    check_val("ret_ra", bus.ra, 32'd21);

    // Reserved fcode and non-branch opcode carrying a call fcode
    bus.fcode = 4'b1011;
    #1;
    check_val("rsv_sel", {31'd0, bus.PC_select}, 32'd0);
    check_val("rsv_pc", {24'd0, bus.branch_PC}, 32'd21);
    edge_step();
    check_val("rsv_ra", bus.ra, 32'd21);
    bus.fcode = 4'b1111;
    #1;
    check_val("rsv15_sel", {31'd0, bus.PC_select}, 32'd0);
    bus.opcode = 3'b100;
    bus.fcode  = 4'b1001;
    bus.PC     = 8'd50;
    #1;
    check_val("nb_sel", {31'd0, bus.PC_select}, 32'd0);
    check_val("nb_pc", {24'd0, bus.branch_PC}, 32'd51);
    edge_step();
    check_val("nb_ra", bus.ra, 32'd21);
    bus.fcode = 4'b0000;
    #1;
    check_val("nb_b_sel", {31'd0, bus.PC_select}, 32'd0);

    // Wrap: call at PC=FF stores 0; not-taken bnz wraps to 0
    bus.opcode = 3'b011;
    bus.fcode  = 4'b1001;
    bus.PC     = 8'hFF;
    edge_step();
    check_val("wrap_ra", bus.ra, 32'd0);
    bus.fcode = 4'b0010;
    set_flags(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    check_val("wrap_sel", {31'd0, bus.PC_select}, 32'd0);
    check_val("wrap_pc", {24'd0, bus.branch_PC}, 32'd0);

    // Asynchronous reset clears ra without a clock edge
    bus.PC    = 8'd40;
    bus.fcode = 4'b1001;
    edge_step();
    check_val("call41_ra", bus.ra, 32'd41);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_ra", bus.ra, 32'd0);

    // Reset held across a call edge wins; ret afterwards jumps to 0
    edge_step();
    check_val("rst_call_ra", bus.ra, 32'd0);
    rst = 1'b0;
    bus.fcode = 4'b1010;
    #1;
    check_val("post_rst_ret_pc", {24'd0, bus.branch_PC}, 32'd0);
    check_val("post_rst_ret_sel", {31'd0, bus.PC_select}, 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
